// File: rtl/adapt_seq_ctrl.sv
// adapt_seq_ctrl: frame sequencer between SPI deserializer, adaptive datapath and serializer.
module adapt_seq_ctrl #(
    parameter int          DW       = 14,
    parameter int          TIMEOUT  = 255,
    parameter logic [DW-1:0] ERR_CODE = 14'h2000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          head_flag,
    input  logic [DW-1:0] buffer_2,
    input  logic [DW-1:0] buffer_3,
    input  logic [DW-1:0] reff,
    input  logic          alg_done,
    input  logic [DW-1:0] alg_dout,
    input  logic          tx_ready,
    input  logic          clr_err,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [DW-1:0] op_ref,
    output logic          alg_start,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    output logic          busy,
    output logic          err_timeout,
    output logic [7:0]    ovr_cnt,
    output logic [7:0]    frame_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, SEND} state_t;

    state_t        state, state_nx;
    logic          head_d, armed;
    logic [TW-1:0] timer;
    logic          head_edge, done_hit, to_hit, ovr_ev, accept;

    // armed masks the first cycle after reset so a head_flag already high is not an edge
    assign head_edge = head_flag & ~head_d & armed;
    assign done_hit  = (state == RUN) & alg_done;
    assign to_hit    = (state == RUN) & ~alg_done & (timer == TW'(TIMEOUT));
    assign ovr_ev    = head_edge & (state != IDLE);
    assign accept    = (state == SEND) & tx_ready;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = head_edge ? START : IDLE;
            START:   state_nx = RUN;
            RUN:     state_nx = (alg_done || to_hit) ? SEND : RUN;
            default: state_nx = tx_ready ? IDLE : SEND;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_d      <= 1'b0;
            armed       <= 1'b0;
            timer       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_ref      <= '0;
            tx_data     <= '0;
            alg_start   <= 1'b0;
            tx_valid    <= 1'b0;
            err_timeout <= 1'b0;
            ovr_cnt     <= 8'd0;
            frame_cnt   <= 8'd0;
        end else begin
            head_d    <= head_flag;
            armed     <= 1'b1;
            alg_start <= (state == IDLE) & head_edge;
            tx_valid  <= state_nx == SEND;
            if ((state == IDLE) && head_edge) begin
                op_a   <= buffer_2;
                op_b   <= buffer_3;
                op_ref <= reff;
            end
            timer <= (state == START) ? '0 :
                     ((state == RUN) && !alg_done && !to_hit) ? timer + 1'b1 : timer;
            if (done_hit)    tx_data <= alg_dout;
            else if (to_hit) tx_data <= ERR_CODE;
            err_timeout <= to_hit | (err_timeout & ~clr_err);
            // a set event in the same cycle as clr_err wins and leaves a count of 1
            ovr_cnt   <= ovr_ev ? (clr_err ? 8'd1 : ovr_cnt + {7'd0, ovr_cnt != 8'hff}) :
                         (clr_err ? 8'd0 : ovr_cnt);
            frame_cnt <= frame_cnt + {7'd0, accept};
        end
    end
endmodule

// File: tb/tb_adapt_seq_ctrl.sv
// tb_adapt_seq_ctrl: directed scenario bench for adapt_seq_ctrl with hand-computed expectations.
module tb_adapt_seq_ctrl;
    logic        clk = 1'b0;
    logic        rstn, head_flag, alg_done, tx_ready, clr_err;
    logic [13:0] buffer_2, buffer_3, reff, alg_dout;
    logic [13:0] op_a, op_b, op_ref, tx_data;
    logic        alg_start, tx_valid, busy, err_timeout;
    logic [7:0]  ovr_cnt, frame_cnt;
    int          nvec = 0;
    int          nerr = 0;

    adapt_seq_ctrl dut (
        .clk(clk), .rstn(rstn), .head_flag(head_flag),
        .buffer_2(buffer_2), .buffer_3(buffer_3), .reff(reff),
        .alg_done(alg_done), .alg_dout(alg_dout), .tx_ready(tx_ready), .clr_err(clr_err),
        .op_a(op_a), .op_b(op_b), .op_ref(op_ref), .alg_start(alg_start),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .err_timeout(err_timeout),
        .ovr_cnt(ovr_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_frame(input logic [13:0] a, input logic [13:0] b, input logic [13:0] r);
        buffer_2  = a;
        buffer_3  = b;
        reff      = r;
        head_flag = 1'b1;
        @(negedge clk);
        head_flag = 1'b0;
    endtask

    task automatic test_reset;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy); end
        nvec++; if (alg_start !== 1'b0 || tx_valid !== 1'b0) begin nerr++; $display("FAIL reset pulses: got start=%b valid=%b want 0 0", alg_start, tx_valid); end
        nvec++; if ({op_a, op_b, op_ref, tx_data} !== 56'd0) begin nerr++; $display("FAIL reset data: got %h %h %h %h want 0", op_a, op_b, op_ref, tx_data); end
        nvec++; if ({err_timeout, ovr_cnt, frame_cnt} !== 17'd0) begin nerr++; $display("FAIL reset status: got err=%b ovr=%0d frm=%0d want 0", err_timeout, ovr_cnt, frame_cnt); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal;
        start_frame(14'h0123, 14'h0456, 14'h0789);
        buffer_2 = 14'h3111; buffer_3 = 14'h3222; reff = 14'h3333;
        nvec++; if (alg_start !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL nominal start: got start=%b busy=%b want 1 1", alg_start, busy); end
        nvec++; if (op_a !== 14'h0123 || op_b !== 14'h0456 || op_ref !== 14'h0789) begin nerr++; $display("FAIL nominal ops: got %h %h %h want 0123 0456 0789", op_a, op_b, op_ref); end
        @(negedge clk);
        nvec++; if (alg_start !== 1'b0) begin nerr++; $display("FAIL nominal start width: got %b want 0", alg_start); end
        @(negedge clk);
        alg_done = 1'b1; alg_dout = 14'h1abc;
        @(negedge clk);
        alg_done = 1'b0; alg_dout = 14'h0;
        nvec++; if (tx_valid !== 1'b1 || tx_data !== 14'h1abc) begin nerr++; $display("FAIL nominal result: got valid=%b data=%h want 1 1abc", tx_valid, tx_data); end
        nvec++; if (frame_cnt !== 8'd0 || alg_start !== 1'b0) begin nerr++; $display("FAIL nominal pre-accept: got frm=%0d start=%b want 0 0", frame_cnt, alg_start); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        nvec++; if (tx_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd1) begin nerr++; $display("FAIL nominal done: got valid=%b busy=%b frm=%0d want 0 0 1", tx_valid, busy, frame_cnt); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        start_frame(14'h0011, 14'h0022, 14'h0033);
        nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL latency start valid: got %b want 0", tx_valid); end
        @(negedge clk);
        alg_done = 1'b1; alg_dout = 14'h0055;
        nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL latency run valid: got %b want 0", tx_valid); end
        @(negedge clk);
        alg_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nvec++; if (tx_valid !== 1'b1 || tx_data !== 14'h0055) begin nerr++; $display("FAIL backpressure cycle %0d: got valid=%b data=%h want 1 0055", i, tx_valid, tx_data); end
            nvec++; if (frame_cnt !== 8'd1) begin nerr++; $display("FAIL backpressure frame_cnt cycle %0d: got %0d want 1", i, frame_cnt); end
            alg_done = (i == 3); alg_dout = 14'h3fff;
            @(negedge clk);
        end
        alg_done = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        nvec++; if (frame_cnt !== 8'd2 || tx_valid !== 1'b0) begin nerr++; $display("FAIL backpressure accept: got frm=%0d valid=%b want 2 0", frame_cnt, tx_valid); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        start_frame(14'h0001, 14'h0002, 14'h0003);
        repeat (256) @(negedge clk);
        nvec++; if (busy !== 1'b1 || tx_valid !== 1'b0 || err_timeout !== 1'b0) begin nerr++; $display("FAIL timeout early: got busy=%b valid=%b err=%b want 1 0 0", busy, tx_valid, err_timeout); end
        @(negedge clk);
        nvec++; if (tx_valid !== 1'b1 || tx_data !== 14'h2000 || err_timeout !== 1'b1) begin nerr++; $display("FAIL timeout fire: got valid=%b data=%h err=%b want 1 2000 1", tx_valid, tx_data, err_timeout); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        nvec++; if (err_timeout !== 1'b1 || frame_cnt !== 8'd3) begin nerr++; $display("FAIL timeout sticky: got err=%b frm=%0d want 1 3", err_timeout, frame_cnt); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        nvec++; if (err_timeout !== 1'b0) begin nerr++; $display("FAIL timeout clear: got %b want 0", err_timeout); end
    endtask

    task automatic test_collision;
        start_frame(14'h0004, 14'h0005, 14'h0006);
        repeat (256) @(negedge clk);
        alg_done = 1'b1; alg_dout = 14'h0aaa;
        @(negedge clk);
        alg_done = 1'b0;
        nvec++; if (tx_data !== 14'h0aaa || err_timeout !== 1'b0 || tx_valid !== 1'b1) begin nerr++; $display("FAIL collision: got data=%h err=%b valid=%b want 0aaa 0 1", tx_data, err_timeout, tx_valid); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overrun;
        start_frame(14'h0111, 14'h0222, 14'h0333);
        buffer_2 = 14'h3333; buffer_3 = 14'h3444; reff = 14'h3555;
        @(negedge clk);
        repeat (3) begin
            head_flag = 1'b1; @(negedge clk);
            head_flag = 1'b0; @(negedge clk);
        end
        nvec++; if (ovr_cnt !== 8'd3 || op_a !== 14'h0111) begin nerr++; $display("FAIL overrun three: got ovr=%0d op_a=%h want 3 0111", ovr_cnt, op_a); end
        alg_done = 1'b1; alg_dout = 14'h0bbb;
        @(negedge clk);
        alg_done = 1'b0;
        repeat (297) begin
            head_flag = 1'b1; @(negedge clk);
            head_flag = 1'b0; @(negedge clk);
        end
        nvec++; if (ovr_cnt !== 8'd255 || tx_valid !== 1'b1) begin nerr++; $display("FAIL overrun saturate: got ovr=%0d valid=%b want 255 1", ovr_cnt, tx_valid); end
        head_flag = 1'b1; clr_err = 1'b1;
        @(negedge clk);
        head_flag = 1'b0; clr_err = 1'b0;
        nvec++; if (ovr_cnt !== 8'd1) begin nerr++; $display("FAIL overrun clr collision: got %0d want 1", ovr_cnt); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        nvec++; if (ovr_cnt !== 8'd0) begin nerr++; $display("FAIL overrun clear: got %0d want 0", ovr_cnt); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        nvec++; if (busy !== 1'b0 || frame_cnt !== 8'd5 || op_a !== 14'h0111 || op_ref !== 14'h0333) begin nerr++; $display("FAIL overrun end: got busy=%b frm=%0d op_a=%h op_ref=%h want 0 5 0111 0333", busy, frame_cnt, op_a, op_ref); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        start_frame(14'h0777, 14'h0888, 14'h0999);
        @(negedge clk);
        head_flag = 1'b1;
        @(negedge clk);
        nvec++; if (ovr_cnt !== 8'd1 || busy !== 1'b1) begin nerr++; $display("FAIL midrun pre-reset: got ovr=%0d busy=%b want 1 1", ovr_cnt, busy); end
        rstn = 1'b0;
        #1;
        nvec++; if (busy !== 1'b0 || alg_start !== 1'b0 || tx_valid !== 1'b0) begin nerr++; $display("FAIL midrun reset ctl: got busy=%b start=%b valid=%b want 0 0 0", busy, alg_start, tx_valid); end
        nvec++; if ({op_a, op_b, op_ref, tx_data} !== 56'd0 || {err_timeout, ovr_cnt, frame_cnt} !== 17'd0) begin nerr++; $display("FAIL midrun reset regs: got %h %h %h %h err=%b ovr=%0d frm=%0d want all 0", op_a, op_b, op_ref, tx_data, err_timeout, ovr_cnt, frame_cnt); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++; if (busy !== 1'b0 || alg_start !== 1'b0 || ovr_cnt !== 8'd0) begin nerr++; $display("FAIL midrun held head cycle %0d: got busy=%b start=%b ovr=%0d want 0 0 0", i, busy, alg_start, ovr_cnt); end
        end
        head_flag = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        for (int i = 1; i <= 256; i++) begin
            start_frame(14'(i), 14'(i + 1), 14'(i + 2));
            @(negedge clk);
            alg_done = 1'b1; alg_dout = 14'(i * 3);
            @(negedge clk);
            alg_done = 1'b0; tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            if (i == 255) begin
                nvec++; if (frame_cnt !== 8'd255) begin nerr++; $display("FAIL wrap 255: got %0d want 255", frame_cnt); end
            end
        end
        nvec++; if (frame_cnt !== 8'd0 || tx_data !== 14'd768 || busy !== 1'b0) begin nerr++; $display("FAIL wrap 256: got frm=%0d data=%h busy=%b want 0 0300 0", frame_cnt, tx_data, busy); end
    endtask

    initial begin
        rstn = 1'b0; head_flag = 1'b0; alg_done = 1'b0; tx_ready = 1'b0; clr_err = 1'b0;
        buffer_2 = '0; buffer_3 = '0; reff = '0; alg_dout = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_nominal;
        test_backpressure;
        test_timeout;
        test_collision;
        test_overrun;
        test_reset_mid_run;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
